// File: rtl/hazard_scoreboard.sv
// Hazard unit for the in-order pipeline: multi-stage forwarding, long-latency busy
// scoreboard, CSR drain/serialise FSM, and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned N_FWD = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [$clog2(NREGS)-1:0]   id_rs1_addr_i,
    input  logic [$clog2(NREGS)-1:0]   id_rs2_addr_i,
    input  logic [$clog2(NREGS)-1:0]   id_rd_addr_i,
    input  logic                       id_long_lat_i,
    input  logic                       id_is_csr_i,
    input  logic                       instr_valid_i,
    input  logic                       load_pc_i,
    input  logic [$clog2(NREGS)-1:0]   ex_rs1_addr_i,
    input  logic [$clog2(NREGS)-1:0]   ex_rs2_addr_i,
    input  logic [N_FWD*$clog2(NREGS)-1:0] fwd_rd_i,
    input  logic [N_FWD-1:0]           fwd_wr_i,
    input  logic [N_FWD-1:0]           fwd_rdy_i,
    input  logic [N_FWD*XLEN-1:0]      fwd_data_i,
    input  logic                       pipe_busy_i,
    input  logic                       sb_set_i,
    input  logic [$clog2(NREGS)-1:0]   sb_set_rd_i,
    input  logic                       sb_clr_i,
    input  logic [$clog2(NREGS)-1:0]   sb_clr_rd_i,
    output logic                       rs1_fwd_o,
    output logic [XLEN-1:0]            rs1_fwd_data_o,
    output logic                       rs2_fwd_o,
    output logic [XLEN-1:0]            rs2_fwd_data_o,
    output logic                       if_id_stall_o,
    output logic                       if_id_flush_o,
    output logic                       id_ex_flush_o,
    output logic                       sb_pending_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [1:0] {IDLE, DRAIN, ISSUE} state_t;

    state_t           state_q, state_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             raw, csr_hold;
    logic             hit1, hit2;
    logic [AW-1:0]    rd0;

    // Forwarding: youngest matching stage wins; an unready winner blocks older stages
    always_comb begin
        rs1_fwd_o      = 1'b0;
        rs1_fwd_data_o = '0;
        rs2_fwd_o      = 1'b0;
        rs2_fwd_data_o = '0;
        hit1           = 1'b0;
        hit2           = 1'b0;
        for (int unsigned i = 0; i < N_FWD; i++) begin
            if (!hit1 && ex_rs1_addr_i != '0 && fwd_wr_i[i] &&
                fwd_rd_i[i*AW +: AW] == ex_rs1_addr_i) begin
                hit1 = 1'b1;
                if (fwd_rdy_i[i]) begin
                    rs1_fwd_o      = 1'b1;
                    rs1_fwd_data_o = fwd_data_i[i*XLEN +: XLEN];
                end
            end
            if (!hit2 && ex_rs2_addr_i != '0 && fwd_wr_i[i] &&
                fwd_rd_i[i*AW +: AW] == ex_rs2_addr_i) begin
                hit2 = 1'b1;
                if (fwd_rdy_i[i]) begin
                    rs2_fwd_o      = 1'b1;
                    rs2_fwd_data_o = fwd_data_i[i*XLEN +: XLEN];
                end
            end
        end
    end

    // RAW: load-use against the youngest stage, busy sources, or WAW on a long-latency rd
    always_comb begin
        rd0 = fwd_rd_i[AW-1:0];
        raw = 1'b0;
        if (instr_valid_i) begin
            if (id_rs1_addr_i != '0 &&
                (busy_q[id_rs1_addr_i] ||
                 (fwd_wr_i[0] && !fwd_rdy_i[0] && rd0 == id_rs1_addr_i)))
                raw = 1'b1;
            if (id_rs2_addr_i != '0 &&
                (busy_q[id_rs2_addr_i] ||
                 (fwd_wr_i[0] && !fwd_rdy_i[0] && rd0 == id_rs2_addr_i)))
                raw = 1'b1;
            if (id_long_lat_i && busy_q[id_rd_addr_i])
                raw = 1'b1;
        end
    end

    // Scoreboard update; set is applied after clear so a same-rd collision stays busy
    always_comb begin
        busy_d = busy_q;
        if (sb_clr_i && sb_clr_rd_i != '0) busy_d[sb_clr_rd_i] = 1'b0;
        if (sb_set_i && sb_set_rd_i != '0) busy_d[sb_set_rd_i] = 1'b1;
    end

    assign sb_pending_o = |busy_q;

    // CSR serialisation FSM next state and stall/flush outputs
    always_comb begin
        state_d  = state_q;
        csr_hold = 1'b0;
        case (state_q)
            IDLE: begin
                csr_hold = id_is_csr_i && instr_valid_i;
                if (instr_valid_i && id_is_csr_i) state_d = DRAIN;
            end
            DRAIN: begin
                csr_hold = 1'b1;
                if (!pipe_busy_i && !sb_pending_o) state_d = ISSUE;
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load_pc_i) state_d = IDLE;

        if_id_stall_o = (raw || csr_hold) && !load_pc_i;
        if_id_flush_o = load_pc_i || (state_q == ISSUE);
        id_ex_flush_o = load_pc_i || !instr_valid_i || raw || csr_hold;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            stall_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (if_id_stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a behavioural model.
module tb_hazard_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int N_FWD = 2;
    localparam int AW    = 5;
    localparam int CNT_W = 32;

    logic clk, rst;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, sb_set_rd, sb_clr_rd;
    logic id_ll, id_csr, iv, lpc, pipe_busy, sb_set, sb_clr;
    logic [N_FWD*AW-1:0]   fwd_rd;
    logic [N_FWD-1:0]      fwd_wr, fwd_rdy;
    logic [N_FWD*XLEN-1:0] fwd_data;
    logic rs1_fwd, rs2_fwd, if_id_stall, if_id_flush, id_ex_flush, sb_pending;
    logic [XLEN-1:0]  rs1_fwd_data, rs2_fwd_data;
    logic [CNT_W-1:0] stall_cnt;

    hazard_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .N_FWD(N_FWD), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd),
        .id_long_lat_i(id_ll), .id_is_csr_i(id_csr), .instr_valid_i(iv),
        .load_pc_i(lpc), .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2),
        .fwd_rd_i(fwd_rd), .fwd_wr_i(fwd_wr), .fwd_rdy_i(fwd_rdy), .fwd_data_i(fwd_data),
        .pipe_busy_i(pipe_busy), .sb_set_i(sb_set), .sb_set_rd_i(sb_set_rd),
        .sb_clr_i(sb_clr), .sb_clr_rd_i(sb_clr_rd),
        .rs1_fwd_o(rs1_fwd), .rs1_fwd_data_o(rs1_fwd_data),
        .rs2_fwd_o(rs2_fwd), .rs2_fwd_data_o(rs2_fwd_data),
        .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
        .id_ex_flush_o(id_ex_flush), .sb_pending_o(sb_pending), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register busy set, CSR mode (0 idle, 1 draining, 2 issuing), counter
    bit               mb[NREGS];
    int               mode;
    logic [CNT_W-1:0] mcnt;
    bit               exp_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pending();
        foreach (mb[r]) if (mb[r]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit src_hazard(input logic [AW-1:0] s);
        if (s == 0) return 1'b0;
        if (mb[s]) return 1'b1;
        return fwd_wr[0] && !fwd_rdy[0] && fwd_rd[AW-1:0] == s;
    endfunction

    task automatic exp_fwd(input logic [AW-1:0] s, output bit f, output logic [XLEN-1:0] d);
        f = 1'b0;
        d = '0;
        for (int i = 0; i < N_FWD; i++) begin
            if (s != 0 && fwd_wr[i] && fwd_rd[i*AW +: AW] == s) begin
                f = fwd_rdy[i];
                d = fwd_data[i*XLEN +: XLEN];
                break;
            end
        end
    endtask

    task automatic check_comb(input string tag);
        bit raw, hold, f1, f2;
        logic [XLEN-1:0] d1, d2;
        raw  = iv && (src_hazard(id_rs1) || src_hazard(id_rs2) || (id_ll && mb[id_rd]));
        hold = (mode == 1) || (mode == 0 && id_csr && iv);
        exp_stall = (raw || hold) && !lpc;
        chk({tag, ".stall"},   64'(if_id_stall), 64'(exp_stall));
        chk({tag, ".ifflush"}, 64'(if_id_flush), 64'(lpc || mode == 2));
        chk({tag, ".exflush"}, 64'(id_ex_flush), 64'(lpc || !iv || raw || hold));
        exp_fwd(ex_rs1, f1, d1);
        exp_fwd(ex_rs2, f2, d2);
        chk({tag, ".rs1fwd"}, 64'(rs1_fwd), 64'(f1));
        if (f1) chk({tag, ".rs1data"}, 64'(rs1_fwd_data), 64'(d1));
        chk({tag, ".rs2fwd"}, 64'(rs2_fwd), 64'(f2));
        if (f2) chk({tag, ".rs2data"}, 64'(rs2_fwd_data), 64'(d2));
        chk({tag, ".pending"}, 64'(sb_pending), 64'(m_pending()));
        chk({tag, ".cnt"},     64'(stall_cnt), 64'(mcnt));
    endtask

    task automatic model_clock();
        bit pend;
        pend = m_pending();
        if (exp_stall && mcnt != '1) mcnt = mcnt + 1'b1;
        if (sb_clr && sb_clr_rd != 0) mb[sb_clr_rd] = 1'b0;
        if (sb_set && sb_set_rd != 0) mb[sb_set_rd] = 1'b1;
        if (lpc) mode = 0;
        else if (mode == 0) mode = (iv && id_csr) ? 1 : 0;
        else if (mode == 1) mode = (!pipe_busy && !pend) ? 2 : 1;
        else mode = 0;
    endtask

    task automatic model_reset();
        foreach (mb[r]) mb[r] = 1'b0;
        mode = 0;
        mcnt = '0;
    endtask

    // Inputs are applied just after a rising edge; outputs checked before the next one
    task automatic cycle(input string tag);
        #3;
        check_comb(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        id_ll = 0; id_csr = 0; iv = 0; lpc = 0; pipe_busy = 0;
        sb_set = 0; sb_clr = 0; sb_set_rd = 0; sb_clr_rd = 0;
        fwd_rd = '0; fwd_wr = '0; fwd_rdy = '0; fwd_data = '0;
    endtask

    task automatic set_stage(input int i, input bit wr, input bit rdy,
                             input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        fwd_wr[i] = wr;
        fwd_rdy[i] = rdy;
        fwd_rd[i*AW +: AW] = rd;
        fwd_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_comb(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clear_in();
        do_reset("reset");

        // Youngest stage wins
        ex_rs1 = 3;
        set_stage(0, 1, 1, 3, 5);
        set_stage(1, 1, 1, 3, 9);
        #2 chk("fwd_young.data", 64'(rs1_fwd_data), 64'd5);
        cycle("fwd_young");
        // Unready youngest blocks ready older stage
        set_stage(0, 1, 0, 3, 5);
        cycle("fwd_block");

        // Load-use: one stall, then the load forwards from stage 1
        clear_in();
        iv = 1; id_rs2 = 7;
        set_stage(0, 1, 0, 7, 0);
        cycle("lu0");
        clear_in();
        iv = 1; ex_rs2 = 7;
        set_stage(1, 1, 1, 7, 32'h77);
        cycle("lu1");

        // Long-latency write of x10: 20 stall cycles
        clear_in();
        do_reset("reset2");
        iv = 1; id_rs1 = 10; sb_set = 1; sb_set_rd = 10;
        cycle("sb0");
        sb_set = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) begin sb_clr = 1; sb_clr_rd = 10; end
            cycle("sb_wait");
        end
        sb_clr = 0;
        cycle("sb_rel");
        chk("sb.stall_cnt", 64'(stall_cnt), 64'd20);

        // CSR drain with busy pipeline, then issue with flush
        clear_in();
        iv = 1; id_csr = 1; pipe_busy = 1;
        cycle("csr_idle");
        cycle("csr_drain1");
        cycle("csr_drain2");
        pipe_busy = 0;
        cycle("csr_drain3");
        id_csr = 0;
        #2 chk("csr_issue.flush", 64'(if_id_flush), 64'd1);
        cycle("csr_issue");
        cycle("csr_done");

        // Redirect during drain
        iv = 1; id_csr = 1; pipe_busy = 1;
        cycle("lpc_idle");
        cycle("lpc_drain");
        lpc = 1;
        #2 chk("lpc.stall", 64'(if_id_stall), 64'd0);
        cycle("lpc_hit");
        lpc = 0; id_csr = 0;
        cycle("lpc_after");

        // Reset mid-drain with x5 busy
        clear_in();
        sb_set = 1; sb_set_rd = 5;
        cycle("rst_set");
        sb_set = 0; iv = 1; id_csr = 1; pipe_busy = 1;
        cycle("rst_idle");
        cycle("rst_drain");
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid.pending", 64'(sb_pending), 64'd0);
        chk("rst_mid.cnt", 64'(stall_cnt), 64'd0);
        check_comb("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_in();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            id_rs1 = AW'($urandom_range(0, 7));
            id_rs2 = AW'($urandom_range(0, 7));
            id_rd  = AW'($urandom_range(0, 7));
            ex_rs1 = AW'($urandom_range(0, 7));
            ex_rs2 = AW'($urandom_range(0, 7));
            id_ll  = ($urandom_range(0, 3) == 0);
            id_csr = ($urandom_range(0, 7) == 0);
            iv     = ($urandom_range(0, 4) != 0);
            lpc    = ($urandom_range(0, 15) == 0);
            pipe_busy = ($urandom_range(0, 1) == 0);
            for (int i = 0; i < N_FWD; i++)
                set_stage(i, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                          AW'($urandom_range(0, 7)), $urandom);
            sb_clr_rd = AW'($urandom_range(0, 7));
            sb_clr    = ($urandom_range(0, 2) == 0);
            sb_set_rd = AW'($urandom_range(0, 7));
            sb_set    = ($urandom_range(0, 5) == 0) && !mb[sb_set_rd];
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
